// File: rtl/key_off_cfg_arb_pkg.sv
// key_off_cfg_arb_pkg
//   Shared definitions for the key-extract offset-table config arbiter:
//   field widths, default sizing, FSM state encoding and requester indices.
package key_off_cfg_arb_pkg;

  localparam int STAGE_ID_WIDTH     = 3;
  localparam int KEY_OFF_ADDR_WIDTH = 4;   // table indexed by tenant = vlan_id[7:4]
  localparam int NUM_STAGE_DEFAULT  = 5;
  localparam int AXIL_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } cfg_state_e;

  // Requester indices; also the bit positions in the arbiter req/gnt vectors.
  localparam logic REQ_A = 1'b0;   // control-plane AXI-Lite decoder
  localparam logic REQ_B = 1'b1;   // in-band config-packet parser

endpackage

// File: rtl/key_off_cfg_arb_rr_arb2.sv
// key_off_cfg_arb_rr_arb2
//   Two-input round-robin arbiter with a one-bit "last granted" pointer.
//   Ports:
//     clk, rst   clock, synchronous active-high reset (pointer -> REQ_B)
//     req[1:0]   request vector, bit REQ_A / REQ_B
//     grant_en   when low no grant is produced
//     update     move the pointer to the current winner
//     gnt[1:0]   combinational one-hot (or zero) grant
module key_off_cfg_arb_rr_arb2
  import key_off_cfg_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    gnt = 2'b00;
    if (grant_en) begin
      if (req == 2'b11) begin
        gnt = (last_q == REQ_B) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (update && (gnt != 2'b00)) begin
      last_d = gnt[REQ_B] ? REQ_B : REQ_A;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/key_off_cfg_arb.sv
// key_off_cfg_arb
//   Shares the write port of every stage's key-extract offset RAM between
//   the AXI-Lite decoder (A) and the in-band config parser (B). Accepted
//   commands become a single one-hot write strobe one cycle later, followed
//   by a mandatory gap cycle, so RAM writes are at least 3 cycles apart.
//   In-band writes may only touch the entry of their own tenant.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     cfg_freeze           blocks new grants; in-flight command completes
//     a_* / b_*            requester command (valid/ready/stage/addr/data)
//     b_tenant             tenant of the packet carrying the B command
//     key_off_entry_out    write data to all stages (holds last latched)
//     key_off_entry_addr   write address to all stages (holds last latched)
//     key_off_entry_valid  one-hot per-stage write strobe
//     cfg_err              one-cycle pulse for a rejected command
//     wr_count, err_count  saturating write / reject counters
//   Stage-id and address widths come from key_off_cfg_arb_pkg.
module key_off_cfg_arb
  import key_off_cfg_arb_pkg::*;
#(
  parameter int NUM_STAGE  = NUM_STAGE_DEFAULT,
  parameter int AXIL_WIDTH = AXIL_WIDTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_freeze,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [STAGE_ID_WIDTH-1:0]     a_stage,
  input  logic [KEY_OFF_ADDR_WIDTH-1:0] a_addr,
  input  logic [AXIL_WIDTH-1:0]         a_data,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [STAGE_ID_WIDTH-1:0]     b_stage,
  input  logic [KEY_OFF_ADDR_WIDTH-1:0] b_addr,
  input  logic [AXIL_WIDTH-1:0]         b_data,
  input  logic [KEY_OFF_ADDR_WIDTH-1:0] b_tenant,
  output logic [AXIL_WIDTH-1:0]         key_off_entry_out,
  output logic [KEY_OFF_ADDR_WIDTH-1:0] key_off_entry_addr,
  output logic [NUM_STAGE-1:0]          key_off_entry_valid,
  output logic                          cfg_err,
  output logic [15:0]                   wr_count,
  output logic [7:0]                    err_count
);

  // One extra bit so NUM_STAGE == 2**STAGE_ID_WIDTH still compares correctly.
  localparam logic [STAGE_ID_WIDTH:0] STAGE_LIMIT = (STAGE_ID_WIDTH+1)'(NUM_STAGE);

  cfg_state_e                    state_q, state_d;
  logic [NUM_STAGE-1:0]          valid_q, valid_d;
  logic                          err_q, err_d;
  logic [KEY_OFF_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXIL_WIDTH-1:0]         data_q, data_d;
  logic [15:0]                   wr_cnt_q, wr_cnt_d;
  logic [7:0]                    err_cnt_q, err_cnt_d;

  logic [1:0]                    gnt;
  logic                          grant_en;
  logic                          accept;
  logic [STAGE_ID_WIDTH-1:0]     sel_stage;
  logic [KEY_OFF_ADDR_WIDTH-1:0] sel_addr;
  logic [AXIL_WIDTH-1:0]         sel_data;
  logic [NUM_STAGE-1:0]          stage_onehot;
  logic                          legal;

  assign grant_en = (state_q == ST_IDLE) && !cfg_freeze;
  assign accept   = (gnt != 2'b00);

  key_off_cfg_arb_rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .req      ({b_valid, a_valid}),
    .grant_en (grant_en),
    .update   (accept),
    .gnt      (gnt)
  );

  assign a_ready = gnt[REQ_A];
  assign b_ready = gnt[REQ_B];

  assign sel_stage = gnt[REQ_B] ? b_stage : a_stage;
  assign sel_addr  = gnt[REQ_B] ? b_addr  : a_addr;
  assign sel_data  = gnt[REQ_B] ? b_data  : a_data;

  // The in-band path may only write the table entry of its own tenant.
  assign legal = ({1'b0, sel_stage} < STAGE_LIMIT) &&
                 (!gnt[REQ_B] || (b_addr == b_tenant));

  for (genvar gi = 0; gi < NUM_STAGE; gi++) begin : g_onehot
    assign stage_onehot[gi] = (sel_stage == STAGE_ID_WIDTH'(gi));
  end

  // Strobe and error flag are decided at accept and registered, so they
  // appear exactly in the WRITE cycle; counters update as WRITE ends.
  always_comb begin
    state_d   = state_q;
    valid_d   = '0;
    err_d     = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WRITE;
          addr_d  = sel_addr;
          data_d  = sel_data;
          valid_d = legal ? stage_onehot : '0;
          err_d   = !legal;
        end
      end
      ST_WRITE: begin
        state_d = ST_GAP;
        if ((valid_q != '0) && (wr_cnt_q != 16'hFFFF)) begin
          wr_cnt_d = wr_cnt_q + 16'd1;
        end
        if (err_q && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      valid_q   <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign key_off_entry_valid = valid_q;
  assign key_off_entry_addr  = addr_q;
  assign key_off_entry_out   = data_q;
  assign cfg_err             = err_q;
  assign wr_count            = wr_cnt_q;
  assign err_count           = err_cnt_q;

endmodule

// File: tb/tb_key_off_cfg_arb.sv
// tb_key_off_cfg_arb
//   Self-checking bench for key_off_cfg_arb. A behavioural model tracks the
//   command lifecycle (accept -> write cycle -> gap cycle), the round-robin
//   preference and the saturating counters; every cycle the full output
//   bundle {a_ready, b_ready, strobe, cfg_err, addr, data, wr_count,
//   err_count} is compared against it, plus directed scenario checks.
module tb_key_off_cfg_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_freeze;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [2:0]  a_stage, b_stage;
  logic [3:0]  a_addr, b_addr, b_tenant;
  logic [31:0] a_data, b_data;
  logic [31:0] key_off_entry_out;
  logic [3:0]  key_off_entry_addr;
  logic [4:0]  key_off_entry_valid;
  logic        cfg_err;
  logic [15:0] wr_count;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  key_off_cfg_arb #(.NUM_STAGE(5), .AXIL_WIDTH(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cfg_freeze          (cfg_freeze),
    .a_valid             (a_valid),
    .a_ready             (a_ready),
    .a_stage             (a_stage),
    .a_addr              (a_addr),
    .a_data              (a_data),
    .b_valid             (b_valid),
    .b_ready             (b_ready),
    .b_stage             (b_stage),
    .b_addr              (b_addr),
    .b_data              (b_data),
    .b_tenant            (b_tenant),
    .key_off_entry_out   (key_off_entry_out),
    .key_off_entry_addr  (key_off_entry_addr),
    .key_off_entry_valid (key_off_entry_valid),
    .cfg_err             (cfg_err),
    .wr_count            (wr_count),
    .err_count           (err_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [67:0] exp_v, obs_v;

  // ---------------- behavioural reference model ----------------
  int          m_phase;    // cycles into the current command: 0 none, 1 write, 2 gap
  logic        m_b_last;   // 1 when B received the most recent grant
  logic        m_legal;
  logic [2:0]  m_stage;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  int          m_wr, m_err;

  function automatic void model_reset();
    m_phase = 0; m_b_last = 1'b1; m_legal = 1'b0; m_stage = '0;
    m_addr = '0; m_data = '0; m_wr = 0; m_err = 0;
  endfunction

  function automatic logic [67:0] model_expect();
    logic       can, ra, rb, err;
    logic [4:0] strobe;
    can    = (m_phase == 0) && !cfg_freeze;
    ra     = can && a_valid && (!b_valid || m_b_last);
    rb     = can && b_valid && (!a_valid || !m_b_last);
    strobe = (m_phase == 1 && m_legal) ? 5'(1 << m_stage) : 5'd0;
    err    = (m_phase == 1) && !m_legal;
    return {ra, rb, strobe, err, m_addr, m_data, 16'(m_wr), 8'(m_err)};
  endfunction

  // Advance the model across one rising edge using the current inputs.
  function automatic void model_commit();
    logic [67:0] e;
    e = model_expect();
    if (rst) begin
      model_reset();
    end else if (m_phase == 1) begin
      if (m_legal) m_wr  = (m_wr  < 65535) ? m_wr  + 1 : 65535;
      else         m_err = (m_err < 255)   ? m_err + 1 : 255;
      m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (e[67] || e[66]) begin
      m_b_last = e[66];
      m_stage  = e[67] ? a_stage : b_stage;
      m_addr   = e[67] ? a_addr  : b_addr;
      m_data   = e[67] ? a_data  : b_data;
      m_legal  = (m_stage < 3'd5) && (e[67] || (b_addr == b_tenant));
      m_phase  = 1;
    end
  endfunction

  function automatic logic [67:0] dut_obs();
    return {a_ready, b_ready, key_off_entry_valid, cfg_err, key_off_entry_addr,
            key_off_entry_out, wr_count, err_count};
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; cfg_freeze = 1'b0;
    a_valid = 1'b0; a_stage = '0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_stage = '0; b_addr = '0; b_data = '0; b_tenant = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk); rst = 1'b0; #1;
    exp_v = model_expect(); obs_v = dut_obs(); n_tests++;
    if (obs_v !== exp_v) begin n_fail++; $display("FAIL reset_model got=%h want=%h", obs_v, exp_v); end
    n_tests++;
    if (obs_v !== 68'h0) begin n_fail++; $display("FAIL reset_zero got=%h want=0", obs_v); end
    model_commit();
  endtask

  task automatic test_first();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      a_valid = (i == 0); a_stage = 3'd2; a_addr = 4'h3; a_data = 32'h0002_A5A5;
      #1;
      exp_v = model_expect(); obs_v = dut_obs(); n_tests++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL first cyc=%0d got=%h want=%h", i, obs_v, exp_v); end
      if (i == 0) begin
        n_tests++;
        if (a_ready !== 1'b1) begin n_fail++; $display("FAIL first_ready got=%b want=1", a_ready); end
      end
      if (i == 1) begin
        n_tests++;
        if ({key_off_entry_valid, key_off_entry_addr, key_off_entry_out} !== {5'b00100, 4'h3, 32'h0002_A5A5}) begin
          n_fail++;
          $display("FAIL first_write got=%b/%h/%h want=00100/3/0002a5a5",
                   key_off_entry_valid, key_off_entry_addr, key_off_entry_out);
        end
      end
      model_commit();
    end
    n_tests++;
    if (wr_count !== 16'd1) begin n_fail++; $display("FAIL first_wr_count got=%0d want=1", wr_count); end
  endtask

  task automatic test_back_to_back();
    int na = 0, nb = 0, prev = -1, alt_bad = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      idle_inputs();
      a_valid = 1'b1; a_stage = 3'($urandom_range(0, 4)); a_addr = 4'($urandom); a_data = $urandom;
      b_valid = 1'b1; b_stage = 3'($urandom_range(0, 4)); b_tenant = 4'($urandom);
      b_addr = b_tenant; b_data = $urandom;
      #1;
      exp_v = model_expect(); obs_v = dut_obs(); n_tests++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL b2b cyc=%0d got=%h want=%h", i, obs_v, exp_v); end
      if (a_ready === 1'b1) begin na++; if (prev == 0) alt_bad++; prev = 0; end
      if (b_ready === 1'b1) begin nb++; if (prev == 1) alt_bad++; prev = 1; end
      model_commit();
    end
    n_tests++;
    if (na != 4 || nb != 4 || alt_bad != 0) begin
      n_fail++; $display("FAIL b2b_grants got A=%0d B=%0d repeats=%0d want 4/4/0", na, nb, alt_bad);
    end
    n_tests++;
    if (wr_count !== 16'd9) begin n_fail++; $display("FAIL b2b_wr_count got=%0d want=9", wr_count); end
  endtask

  task automatic test_tenant_reject();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      b_valid = (i == 0); b_stage = 3'd1; b_tenant = 4'h5; b_addr = 4'h6; b_data = 32'hDEAD_0001;
      #1;
      exp_v = model_expect(); obs_v = dut_obs(); n_tests++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL tenant cyc=%0d got=%h want=%h", i, obs_v, exp_v); end
      if (i == 1) begin
        n_tests++;
        if (cfg_err !== 1'b1 || key_off_entry_valid !== 5'b0) begin
          n_fail++; $display("FAIL tenant_err got err=%b strobe=%b want 1/00000", cfg_err, key_off_entry_valid);
        end
      end
      model_commit();
    end
    n_tests++;
    if (err_count !== 8'd1) begin n_fail++; $display("FAIL tenant_err_count got=%0d want=1", err_count); end
  endtask

  task automatic test_bad_stage();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      a_valid = (i == 0); a_stage = 3'd6; a_addr = 4'h2; a_data = 32'h1234_5678;
      #1;
      exp_v = model_expect(); obs_v = dut_obs(); n_tests++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL stage cyc=%0d got=%h want=%h", i, obs_v, exp_v); end
      if (i == 1) begin
        n_tests++;
        if (cfg_err !== 1'b1 || key_off_entry_valid !== 5'b0) begin
          n_fail++; $display("FAIL stage_err got err=%b strobe=%b want 1/00000", cfg_err, key_off_entry_valid);
        end
      end
      model_commit();
    end
    n_tests++;
    if (err_count !== 8'd2 || wr_count !== 16'd9) begin
      n_fail++; $display("FAIL stage_counts got wr=%0d err=%0d want 9/2", wr_count, err_count);
    end
  endtask

  task automatic test_freeze();
    int frozen_ready = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      idle_inputs();
      a_valid = (i == 0); a_stage = 3'd4; a_addr = 4'hA; a_data = 32'hF00D_0004;
      cfg_freeze = (i >= 1 && i <= 10);
      b_valid = (i >= 1 && i <= 11); b_stage = 3'd0; b_tenant = 4'h7; b_addr = 4'h7; b_data = 32'hBEEF_0000;
      #1;
      exp_v = model_expect(); obs_v = dut_obs(); n_tests++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL freeze cyc=%0d got=%h want=%h", i, obs_v, exp_v); end
      if (i == 1) begin
        n_tests++;
        if (key_off_entry_valid !== 5'b10000) begin
          n_fail++; $display("FAIL freeze_inflight got=%b want=10000", key_off_entry_valid);
        end
      end
      if (cfg_freeze && b_ready === 1'b1) frozen_ready++;
      if (i == 11) begin
        n_tests++;
        if (b_ready !== 1'b1) begin n_fail++; $display("FAIL freeze_release got=%b want=1", b_ready); end
      end
      model_commit();
    end
    n_tests++;
    if (frozen_ready != 0) begin n_fail++; $display("FAIL freeze_stall got=%0d want=0", frozen_ready); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i < 397) begin
        cfg_freeze = ($urandom_range(0, 7) == 0);
        a_valid = 1'($urandom); a_stage = 3'($urandom); a_addr = 4'($urandom); a_data = $urandom;
        b_valid = 1'($urandom); b_stage = 3'($urandom); b_tenant = 4'($urandom);
        b_addr = ($urandom_range(0, 2) != 0) ? b_tenant : 4'($urandom);
        b_data = $urandom;
      end
      #1;
      exp_v = model_expect(); obs_v = dut_obs(); n_tests++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs_v, exp_v); end
      model_commit();
    end
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 780; i++) begin
      @(negedge clk);
      idle_inputs();
      b_valid = 1'b1; b_stage = 3'd2; b_tenant = 4'h0; b_addr = 4'h1; b_data = 32'(i);
      #1;
      exp_v = model_expect(); obs_v = dut_obs(); n_tests++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL errsat cyc=%0d got=%h want=%h", i, obs_v, exp_v); end
      model_commit();
    end
    n_tests++;
    if (err_count !== 8'hFF) begin n_fail++; $display("FAIL errsat_count got=%0d want=255", err_count); end
  endtask

  task automatic test_wr_saturate();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i == 0) begin
        force dut.wr_cnt_q = 16'hFFFE;
        m_wr = 65534;
      end
      if (i == 1) release dut.wr_cnt_q;
      a_valid = (i >= 1); a_stage = 3'd0; a_addr = 4'(i); a_data = 32'hC0DE_0000 + 32'(i);
      #1;
      exp_v = model_expect(); obs_v = dut_obs(); n_tests++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL wrsat cyc=%0d got=%h want=%h", i, obs_v, exp_v); end
      model_commit();
    end
    n_tests++;
    if (wr_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrsat_count got=%h want=ffff", wr_count); end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_inputs();
      a_valid = (i == 0 || i == 3); a_stage = 3'd4; a_addr = 4'h9; a_data = 32'h5555_AAAA;
      rst = (i == 1 || i == 3);
      #1;
      exp_v = model_expect(); obs_v = dut_obs(); n_tests++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL rstmid cyc=%0d got=%h want=%h", i, obs_v, exp_v); end
      if (i == 1) begin
        n_tests++;
        if (key_off_entry_valid !== 5'b10000) begin
          n_fail++; $display("FAIL rstmid_write got=%b want=10000", key_off_entry_valid);
        end
      end
      if (i == 2) begin
        n_tests++;
        if (obs_v !== 68'h0) begin n_fail++; $display("FAIL rstmid_zero got=%h want=0", obs_v); end
      end
      if (i == 4) begin
        n_tests++;
        if (key_off_entry_valid !== 5'b0 || cfg_err !== 1'b0) begin
          n_fail++; $display("FAIL rst_accept_suppress got=%b/%b want=00000/0", key_off_entry_valid, cfg_err);
        end
      end
      model_commit();
    end
  endtask

  initial begin
    test_reset();
    test_first();
    test_back_to_back();
    test_tenant_reject();
    test_bad_stage();
    test_freeze();
    test_random();
    test_err_saturate();
    test_wr_saturate();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
